arbitro_hamming: RTL



---
 rtl/arbitro_hamming.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/arbitro_hamming.sv
// Two-channel round-robin arbiter with packet lock feeding a Hamming(15,11) SEC decoder.
// Optional per-channel corrected-error counters are built when HAMMING_ERR_CNT_EN is defined.
module arbitro_hamming #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [14:0]      in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [14:0]      in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic             out_chan,
    output logic             out_last,
    output logic [3:0]       out_syndrome,
    output logic             out_corrected,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [1:0]       fsm_state
);

    // Handshake: a beat moves on a channel exactly in a cycle where its valid and
    // ready are both 1; ready never depends on data, and out_* may only change
    // while out_valid is 0 or out_ready is 1.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   last_grant_nxt;

    logic        grant0;
    logic        grant1;
    logic        out_free;
    logic        acc0;
    logic        acc1;
    logic        accept;

    logic [14:0] sel_cw;
    logic        sel_last;
    logic [3:0]  syn;
    logic [14:0] flip;
    logic [14:0] fixed_cw;
    logic [10:0] dec_data;

    assign fsm_state = state;

    // In IDLE the channel other than last_grant wins a contention.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            IDLE: begin
                grant0 = in0_valid & (~in1_valid | last_grant);
                grant1 = in1_valid & (~in0_valid | ~last_grant);
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: ;
        endcase
    end

    assign out_free  = ~out_valid | out_ready;
    assign in0_ready = ~rst & grant0 & out_free;
    assign in1_ready = ~rst & grant1 & out_free;
    assign acc0      = in0_valid & in0_ready;
    assign acc1      = in1_valid & in1_ready;
    assign accept    = acc0 | acc1;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (acc0) begin
            state_nxt      = in0_last ? IDLE : LOCK0;
            last_grant_nxt = 1'b0;
        end else if (acc1) begin
            state_nxt      = in1_last ? IDLE : LOCK1;
            last_grant_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    assign sel_cw   = grant1 ? in1_data : in0_data;
    assign sel_last = grant1 ? in1_last : in0_last;

    // Masks select the codeword indices whose Hamming position has syndrome bit k set.
    assign syn[0] = ^(sel_cw & 15'h5555);
    assign syn[1] = ^(sel_cw & 15'h6666);
    assign syn[2] = ^(sel_cw & 15'h7878);
    assign syn[3] = ^(sel_cw & 15'h7F80);

    always_comb begin
        flip = '0;
        if (syn != 4'd0) begin
            flip[syn - 4'd1] = 1'b1;
        end
    end

    assign fixed_cw = sel_cw ^ flip;
    assign dec_data = {fixed_cw[14:8], fixed_cw[6:4], fixed_cw[2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_chan      <= 1'b0;
            out_last      <= 1'b0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_data      <= dec_data;
            out_chan      <= acc1;
            out_last      <= sel_last;
            out_syndrome  <= syn;
            out_corrected <= (syn != 4'd0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (clr_cnt) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (syn != 4'd0) begin
            if (acc0 && (err_cnt0 != '1)) begin
                err_cnt0 <= err_cnt0 + CNT_W'(1);
            end
            if (acc1 && (err_cnt1 != '1)) begin
                err_cnt1 <= err_cnt1 + CNT_W'(1);
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign err_cnt0   = '0;
    assign err_cnt1   = '0;
`endif

endmodule
